rampipe_ctrl: RTL and testbench

Request-side controller that drives a `rampipe` instance (128x16 RAM macro plus output pipeline register). It accepts read/write requests on a valid/ready interface and converts them into cycle-accurate macro control: active-low WEN/OEN, address and write data. It tracks the fixed read latency and returns read data on a backpressurable valid/ready response channel through a small FIFO. Sits between the bus-side logic and `rampipe`, and is the only block that drives the RAM pins.

---
 rtl/rampipe_ctrl.sv | 119 +++++++++++
 tb/tb_rampipe_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rampipe_ctrl.sv
// rampipe_ctrl: turns valid/ready read/write requests into rampipe macro pin timing and returns read data through a small FIFO.
// Define RAMPIPE_CTRL_STATS_EN to build saturating accepted-read/write counters; otherwise stat ports are tied to 0.
module rampipe_ctrl #(
    parameter int AW        = 7,
    parameter int DW        = 16,
    parameter int RSP_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] ram_A,
    output logic [DW-1:0] ram_D,
    output logic          ram_WEN,
    output logic          ram_OEN,
    input  logic [DW-1:0] ram_Q,
    output logic [15:0]   stat_rd_cnt,
    output logic [15:0]   stat_wr_cnt
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = CW + 1;

    logic [1:0]    rd_pipe_q, rd_pipe_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] fifo_mem [RSP_DEPTH];
    logic [IW-1:0] inflight;
    logic          hs, hs_rd, hs_wr, push, pop;

    // Valid/ready on both channels: a transfer happens in a cycle where valid and ready
    // are both high; ready never looks at valid, and the producer holds its payload until taken.
    // Every accepted read owns one credit until it is popped, so the FIFO cannot overflow.
    assign inflight  = IW'(count_q) + IW'(rd_pipe_q[0]) + IW'(rd_pipe_q[1]);
    assign req_ready = !RST && (inflight < IW'(RSP_DEPTH));

    assign hs    = req_valid && req_ready;
    assign hs_rd = hs && !req_we;
    assign hs_wr = hs && req_we;

    assign ram_A   = hs ? req_addr : '0;
    assign ram_D   = hs ? req_wdata : '0;
    assign ram_WEN = !hs_wr;
    assign ram_OEN = !(rd_pipe_q[0] && !RST);

    assign rsp_valid = !RST && (count_q != '0);
    assign rsp_rdata = fifo_mem[rd_ptr_q];

    // rd_pipe[1] marks the cycle the rampipe output register holds this read's data.
    assign push = rd_pipe_q[1] && !RST;
    assign pop  = rsp_valid && rsp_ready;

    always_comb begin
        rd_pipe_d = {rd_pipe_q[0], hs_rd};
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pipe_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= ram_Q;
        end
    end

`ifdef RAMPIPE_CTRL_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (hs_rd && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
        end
        if (hs_wr && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_cnt = RST ? 16'h0 : rd_cnt_q;
    assign stat_wr_cnt = RST ? 16'h0 : wr_cnt_q;
`else
    assign stat_rd_cnt = 16'h0;
    assign stat_wr_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_rampipe_ctrl.sv
// tb_rampipe_ctrl: drives rampipe_ctrl against a behavioural rampipe macro and checks every cycle
// against a transaction-level model (outstanding-read queue, memory image, counters).
module tb_rampipe_ctrl;
    localparam int AW        = 7;
    localparam int DW        = 16;
    localparam int RSP_DEPTH = 4;
`ifdef RAMPIPE_CTRL_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] ram_A;
    logic [DW-1:0] ram_D;
    logic          ram_WEN;
    logic          ram_OEN;
    logic [DW-1:0] ram_Q;
    logic [15:0]   stat_rd_cnt;
    logic [15:0]   stat_wr_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    rampipe_ctrl #(.AW(AW), .DW(DW), .RSP_DEPTH(RSP_DEPTH)) dut (
        .CLK        (clk),
        .RST        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .ram_A      (ram_A),
        .ram_D      (ram_D),
        .ram_WEN    (ram_WEN),
        .ram_OEN    (ram_OEN),
        .ram_Q      (ram_Q),
        .stat_rd_cnt(stat_rd_cnt),
        .stat_wr_cnt(stat_wr_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 50000", $time);
        $fatal(1, "watchdog expired");
    end

    // rampipe stand-in: synchronous macro read, then an output register that only
    // captures real data while OEN is low.
    logic [DW-1:0] ram_mem [128];
    logic [DW-1:0] macro_q;
    logic [DW-1:0] pipe_q;

    always @(posedge clk) begin
        if (!ram_WEN) ram_mem[ram_A] <= ram_D;
        macro_q <= ram_mem[ram_A];
        pipe_q  <= ram_OEN ? 16'hDEAD : macro_q;
    end
    assign ram_Q = pipe_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // scoreboard / model state
    logic [DW-1:0] exp_q [$];
    int            rdy_q [$];
    logic [DW-1:0] model_mem [128];
    logic          prev_rd = 1'b0;
    logic [15:0]   m_rd_cnt = 16'h0;
    logic [15:0]   m_wr_cnt = 16'h0;
    logic          m_ready, m_hs, m_rv;

    always @(negedge clk) begin
        m_ready = !rst && (exp_q.size() < RSP_DEPTH);
        m_hs    = req_valid && m_ready;
        m_rv    = !rst && (exp_q.size() > 0) && (rdy_q[0] <= cyc);

        chk("req_ready", req_ready, m_ready);
        chk("ram_WEN", ram_WEN, !(m_hs && req_we));
        chk("ram_A", ram_A, m_hs ? req_addr : 7'd0);
        chk("ram_D", ram_D, m_hs ? req_wdata : 16'd0);
        chk("ram_OEN", ram_OEN, !(prev_rd && !rst));
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_rv) chk("rsp_rdata", rsp_rdata, exp_q[0]);
        chk("stat_rd_cnt", stat_rd_cnt, (STATS_ON && !rst) ? m_rd_cnt : 16'h0);
        chk("stat_wr_cnt", stat_wr_cnt, (STATS_ON && !rst) ? m_wr_cnt : 16'h0);

        // a FIFO push while full with no simultaneous pop is an overflow
        if (!rst && dut.rd_pipe_q[1] && !(rsp_valid && rsp_ready))
            chk("fifo_no_overflow", 32'(dut.count_q < RSP_DEPTH), 1);

        if (rst) begin
            exp_q.delete();
            rdy_q.delete();
            prev_rd  = 1'b0;
            m_rd_cnt = 16'h0;
            m_wr_cnt = 16'h0;
        end else begin
            if (m_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                void'(rdy_q.pop_front());
            end
            if (m_hs && !req_we) begin
                exp_q.push_back(model_mem[req_addr]);
                rdy_q.push_back(cyc + 3);
                if (m_rd_cnt != 16'hFFFF) m_rd_cnt++;
            end
            if (m_hs && req_we) begin
                model_mem[req_addr] = req_wdata;
                if (m_wr_cnt != 16'hFFFF) m_wr_cnt++;
            end
            prev_rd = m_hs && !req_we;
        end
    end

    // response collector for the hand-computed checks
    logic [DW-1:0] got_d [$];
    int            got_c [$];

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            got_d.push_back(rsp_rdata);
            got_c.push_back(cyc);
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int acc_cyc);
        int waited = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: request addr 0x%0h not accepted within 50 cycles", a);
            acc_cyc = -1;
        end else begin
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string name);
        int w = 0;
        while (got_d.size() < n && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk(name, got_d.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_d.delete();
        got_c.delete();
    endtask

    initial begin
        int cw, cr, acc_n, c1, c2;
        int acc [8];
        logic [DW-1:0] st_exp [5];

        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'h03;
        req_wdata = 16'h0;
        rsp_ready = 1'b1;

        // reset with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_ram_WEN", ram_WEN, 1);
            chk("rst_ram_OEN", ram_OEN, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_rsp", got_d.size(), 0);

        // write then read same address on the next cycle
        clear_got();
        issue(1'b1, 7'h05, 16'hBEEF, cw);
        issue(1'b0, 7'h05, 16'h0, cr);
        chk("wr_rd_adjacent", cr - cw, 1);
        wait_rsp(1, "wr_rd_rsp_count");
        if (got_d.size() > 0) begin
            chk("wr_rd_data", got_d[0], 16'hBEEF);
            chk("wr_rd_latency", got_c[0] - cr, 3);
        end

        // preload and back-to-back reads
        for (int k = 0; k < 8; k++) issue(1'b1, 7'(k), 16'h1000 + 16'(k), cw);
        clear_got();
        for (int k = 0; k < 8; k++) issue(1'b0, 7'(k), 16'h0, acc[k]);
        for (int k = 1; k < 8; k++) chk("b2b_accept_cycle", acc[k] - acc[0], k);
        wait_rsp(8, "b2b_rsp_count");
        for (int k = 0; k < 8; k++) begin
            if (got_d.size() > k) begin
                chk("b2b_data", got_d[k], 16'h1000 + k);
                chk("b2b_rsp_cycle", got_c[k] - acc[0], 3 + k);
            end
        end

        // backpressure: only RSP_DEPTH reads get in
        clear_got();
        rsp_ready = 1'b0;
        acc_n     = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 7'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready && acc_n < 6) acc_n++;
            @(posedge clk);
            #1;
            req_addr = 7'(acc_n);
            if (acc_n >= 6) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc_n, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_pop", got_d.size(), 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_at_first_pop", req_ready, 0);
        @(negedge clk);
        chk("bp_ready_after_pop", req_ready, 1);
        @(posedge clk);
        #1;
        wait_rsp(4, "bp_rsp_count");
        for (int k = 0; k < 4; k++)
            if (got_d.size() > k) chk("bp_data", got_d[k], 16'h1000 + k);

        // reset while two reads are in flight
        clear_got();
        issue(1'b0, 7'h01, 16'h0, c1);
        issue(1'b0, 7'h02, 16'h0, c2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_rsp", got_d.size(), 0);
        issue(1'b0, 7'h03, 16'h0, cr);
        wait_rsp(1, "rst_mid_rsp_count");
        if (got_d.size() > 0) begin
            chk("rst_mid_data", got_d[0], 16'h1003);
            chk("rst_mid_latency", got_c[0] - cr, 3);
        end

        // counters: 3 writes, 5 reads after a fresh reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_got();
        for (int k = 0; k < 3; k++) issue(1'b1, 7'(20 + k), 16'h2000 + 16'(k), cw);
        issue(1'b0, 7'd20, 16'h0, cr);
        issue(1'b0, 7'd21, 16'h0, cr);
        issue(1'b0, 7'd22, 16'h0, cr);
        issue(1'b0, 7'd20, 16'h0, cr);
        issue(1'b0, 7'd21, 16'h0, cr);
        st_exp[0] = 16'h2000;
        st_exp[1] = 16'h2001;
        st_exp[2] = 16'h2002;
        st_exp[3] = 16'h2000;
        st_exp[4] = 16'h2001;
        wait_rsp(5, "stat_rsp_count");
        for (int k = 0; k < 5; k++)
            if (got_d.size() > k) chk("stat_data", got_d[k], st_exp[k]);
        chk("stat_wr_final", stat_wr_cnt, STATS_ON ? 3 : 0);
        chk("stat_rd_final", stat_rd_cnt, STATS_ON ? 5 : 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
